// File: rtl/hazard_stall_pkg.sv
// Shared pipeline control definitions for the 5-stage MIPS core.
// Holds the instruction classes used by the hazard logic, the Tuse/Tnew
// timing constants, the multiply/divide funct codes, default mult/div
// occupancy and the ctrl decoder that classifies an instruction word.
package hazard_stall_pkg;

  // Operand-use and result-ready timing, in cycles relative to ID / EX entry.
  localparam logic [1:0] TUSE_0 = 2'd0;
  localparam logic [1:0] TUSE_1 = 2'd1;
  localparam logic [1:0] TUSE_2 = 2'd2;
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Primary opcodes.
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes with hazard-relevant behaviour.
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_CALC_R,
    CLS_CALC_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JR,
    CLS_JAL,
    CLS_MD,
    CLS_MF,
    CLS_MT
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic         rs_used;
    logic         rt_used;
    logic [1:0]   tuse_rs;
    logic [1:0]   tuse_rt;
    logic         writes;   // produces a GPR result tracked by the scoreboard
    logic [1:0]   tnew;     // cycles until result is forwardable, on EX entry
    logic         md_op;    // mult/multu/div/divu
    logic         md_div;   // div/divu (longer occupancy)
    logic         hilo_op;  // md, mf or mt: needs the mult/div unit idle
  } decode_t;

  function automatic decode_t decode(input logic [31:0] instr);
    decode_t    d;
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];

    d         = '0;
    d.cls     = CLS_NONE;
    d.rs      = instr[25:21];
    d.rt      = instr[20:16];

    if (op == OP_SPECIAL) begin
      unique case (fn)
        FN_JR:                         d.cls = CLS_JR;
        FN_MULT, FN_MULTU,
        FN_DIV,  FN_DIVU:              d.cls = CLS_MD;
        FN_MFHI, FN_MFLO:              d.cls = CLS_MF;
        FN_MTHI, FN_MTLO:              d.cls = CLS_MT;
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
        6'h26, 6'h27, 6'h2a, 6'h2b:    d.cls = CLS_CALC_R;
        default:                       d.cls = CLS_NONE;
      endcase
    end else begin
      unique case (op)
        OP_JAL:                                  d.cls = CLS_JAL;
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:        d.cls = CLS_BRANCH;
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI:        d.cls = CLS_CALC_I;
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:     d.cls = CLS_LOAD;
        OP_SB, OP_SH, OP_SW:                     d.cls = CLS_STORE;
        default:                                 d.cls = CLS_NONE;
      endcase
    end

    unique case (d.cls)
      CLS_BRANCH: begin
        d.rs_used = 1'b1; d.tuse_rs = TUSE_0;
        d.rt_used = 1'b1; d.tuse_rt = TUSE_0;
      end
      CLS_JR: begin
        d.rs_used = 1'b1; d.tuse_rs = TUSE_0;
      end
      CLS_CALC_R: begin
        d.rs_used = 1'b1; d.tuse_rs = TUSE_1;
        d.rt_used = 1'b1; d.tuse_rt = TUSE_1;
        d.writes  = 1'b1; d.tnew    = TNEW_1;
      end
      CLS_CALC_I: begin
        d.rs_used = 1'b1; d.tuse_rs = TUSE_1;
        d.writes  = 1'b1; d.tnew    = TNEW_1;
      end
      CLS_LOAD: begin
        d.rs_used = 1'b1; d.tuse_rs = TUSE_1;
        d.writes  = 1'b1; d.tnew    = TNEW_2;
      end
      CLS_STORE: begin
        d.rs_used = 1'b1; d.tuse_rs = TUSE_1;
        d.rt_used = 1'b1; d.tuse_rt = TUSE_2;   // store data is needed only in MEM
      end
      CLS_MD: begin
        d.rs_used = 1'b1; d.tuse_rs = TUSE_1;
        d.rt_used = 1'b1; d.tuse_rt = TUSE_1;
        d.md_op   = 1'b1;
        d.md_div  = (fn == FN_DIV) || (fn == FN_DIVU);
        d.hilo_op = 1'b1;
      end
      CLS_MF: begin
        d.writes  = 1'b1; d.tnew    = TNEW_1;
        d.hilo_op = 1'b1;
      end
      CLS_MT: begin
        d.rs_used = 1'b1; d.tuse_rs = TUSE_1;
        d.hilo_op = 1'b1;
      end
      CLS_JAL: begin
        d.writes  = 1'b1; d.tnew    = TNEW_0;   // link value is forwarded straight from EX
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hazard_stall_md_busy_counter.sv
// Multiply/divide occupancy tracker.
//   clk, rst     : pipeline clock, asynchronous active-high reset
//   md_issue_i   : an md instruction leaves ID this cycle (not stalled)
//   md_is_div_i  : that instruction is div/divu
//   md_busy_o    : unit occupied (down-counter non-zero)
//   md_start_o   : md operation sits in EX this cycle (one-cycle pulse)
module md_busy_counter
  import hazard_stall_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic md_issue_i,
  input  logic md_is_div_i,
  output logic md_busy_o,
  output logic md_start_o
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  logic             md_ex_q,  md_ex_d;
  logic             op_div_q, op_div_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    md_ex_d  = md_issue_i;
    op_div_d = md_issue_i ? md_is_div_i : op_div_q;
    count_d  = count_q;
    // A start in EX reloads even if a count is still pending.
    if (md_ex_q) begin
      count_d = op_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_ex_q  <= 1'b0;
      op_div_q <= 1'b0;
      count_q  <= '0;
    end else begin
      md_ex_q  <= md_ex_d;
      op_div_q <= op_div_d;
      count_q  <= count_d;
    end
  end

  assign md_busy_o  = (count_q != '0);
  assign md_start_o = md_ex_q;

endmodule

// File: rtl/hazard_stall.sv
// Stall unit for the 5-stage MIPS pipeline. Detects consumers in ID whose
// operand cannot yet be forwarded, and HI/LO-class instructions that must
// wait for the mult/div unit, then freezes PC/IF-ID and bubbles ID/EX.
//   clk, rst  : pipeline clock, asynchronous active-high reset
//   Instr_ID  : instruction word in IF/ID
//   RegA3_ID  : destination register resolved in ID (0 = no write)
//   Stall     : freeze PC and IF/ID, clear ID/EX
//   MDBusy    : mult/div unit occupied
//   MDStart   : md operation entered EX this cycle
module hazard_stall
  import hazard_stall_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr_ID,
  input  logic [4:0]  RegA3_ID,
  output logic        Stall,
  output logic        MDBusy,
  output logic        MDStart
);

  decode_t    id_dec;
  logic [4:0] ex_a3_q,   ex_a3_d;
  logic [1:0] ex_tnew_q, ex_tnew_d;
  logic [4:0] mem_a3_q,  mem_a3_d;
  logic [1:0] mem_tnew_q, mem_tnew_d;
  logic       data_stall;
  logic       md_stall;
  logic       md_issue;

  always_comb id_dec = decode(Instr_ID);

  // The youngest matching producer decides: if EX writes r, MEM's copy of r
  // is stale and is never the forwarding source.
  function automatic logic operand_stall(input logic [4:0] r,
                                         input logic       used,
                                         input logic [1:0] tuse,
                                         input logic [4:0] ex_a3,
                                         input logic [1:0] ex_tnew,
                                         input logic [4:0] mem_a3,
                                         input logic [1:0] mem_tnew);
    logic s;
    s = 1'b0;
    if (used && r != 5'd0) begin
      if (r == ex_a3)       s = (ex_tnew  > tuse);
      else if (r == mem_a3) s = (mem_tnew > tuse);
    end
    return s;
  endfunction

  always_comb begin
    data_stall = operand_stall(id_dec.rs, id_dec.rs_used, id_dec.tuse_rs,
                               ex_a3_q, ex_tnew_q, mem_a3_q, mem_tnew_q)
               | operand_stall(id_dec.rt, id_dec.rt_used, id_dec.tuse_rt,
                               ex_a3_q, ex_tnew_q, mem_a3_q, mem_tnew_q);
    md_stall   = id_dec.hilo_op && (MDBusy || MDStart);
    Stall      = data_stall || md_stall;
    md_issue   = id_dec.md_op && !Stall;
  end

  // Scoreboard advance: a stalled ID slot becomes a bubble in EX; results
  // age by one cycle moving from EX to MEM.
  always_comb begin
    ex_a3_d    = 5'd0;
    ex_tnew_d  = TNEW_0;
    if (!Stall && id_dec.writes) begin
      ex_a3_d   = RegA3_ID;
      ex_tnew_d = id_dec.tnew;
    end
    mem_a3_d   = ex_a3_q;
    mem_tnew_d = (ex_tnew_q != TNEW_0) ? ex_tnew_q - 2'd1 : TNEW_0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_a3_q    <= 5'd0;
      ex_tnew_q  <= TNEW_0;
      mem_a3_q   <= 5'd0;
      mem_tnew_q <= TNEW_0;
    end else begin
      ex_a3_q    <= ex_a3_d;
      ex_tnew_q  <= ex_tnew_d;
      mem_a3_q   <= mem_a3_d;
      mem_tnew_q <= mem_tnew_d;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk         (clk),
    .rst         (rst),
    .md_issue_i  (md_issue),
    .md_is_div_i (id_dec.md_div),
    .md_busy_o   (MDBusy),
    .md_start_o  (MDStart)
  );

endmodule

// File: tb/tb_hazard_stall.sv
module tb_hazard_stall;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instr_ID;
  logic [4:0]  RegA3_ID;
  logic        Stall;
  logic        MDBusy;
  logic        MDStart;

  int checks   = 0;
  int failures = 0;

  hazard_stall dut (
    .clk      (clk),
    .rst      (rst),
    .Instr_ID (Instr_ID),
    .RegA3_ID (RegA3_ID),
    .Stall    (Stall),
    .MDBusy   (MDBusy),
    .MDStart  (MDStart)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [4:0] a3);
    Instr_ID = instr;
    RegA3_ID = a3;
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    Instr_ID = 32'h0;
    RegA3_ID = 5'd0;
    #2;
    check("reset_stall",   Stall,   1'b0);
    check("reset_mdbusy",  MDBusy,  1'b0);
    check("reset_mdstart", MDStart, 1'b0);
    tick();
    rst = 1'b0;
    #1;

    // Load-use: lw $1 then addu $2,$1,$3 -> exactly one stall cycle.
    drive(enc_i(6'h23, 5'd2, 5'd1, 16'h0), 5'd1);
    check("lw1_issue", Stall, 1'b0);
    tick();
    drive(enc_r(5'd1, 5'd3, 5'd2, 6'h21), 5'd2);
    check("load_use_stall", Stall, 1'b1);
    tick();
    check("load_use_release", Stall, 1'b0);
    tick();

    // Branch after calc: addu $4 in EX, beq $4,$0 in ID.
    drive(enc_r(5'd5, 5'd6, 5'd4, 6'h21), 5'd4);
    check("addu4_issue", Stall, 1'b0);
    tick();
    drive(enc_i(6'h04, 5'd4, 5'd0, 16'h4), 5'd0);
    check("branch_calc_stall", Stall, 1'b1);
    tick();
    check("branch_calc_release", Stall, 1'b0);
    tick();

    // Store data: rt needed late (no stall), base needed early (stall).
    drive(enc_i(6'h23, 5'd7, 5'd5, 16'h0), 5'd5);
    check("lw5_issue", Stall, 1'b0);
    tick();
    drive(enc_i(6'h2b, 5'd6, 5'd5, 16'h0), 5'd0);
    check("store_data_no_stall", Stall, 1'b0);
    drive(enc_i(6'h2b, 5'd5, 5'd6, 16'h0), 5'd0);
    check("store_base_stall", Stall, 1'b1);
    tick();
    check("store_base_release", Stall, 1'b0);
    tick();

    // $0 immunity: addu $0 in EX, beq $0,$0 in ID.
    drive(enc_r(5'd1, 5'd1, 5'd0, 6'h21), 5'd0);
    tick();
    drive(enc_i(6'h04, 5'd0, 5'd0, 16'h1), 5'd0);
    check("zero_reg_no_stall", Stall, 1'b0);
    tick();

    // EX precedence: lw $31 in MEM (Tnew 1), jal in EX (Tnew 0), jr $31 in ID.
    drive(enc_i(6'h23, 5'd0, 5'd31, 16'h0), 5'd31);
    tick();
    drive({6'h03, 26'h10}, 5'd31);
    check("jal_issue", Stall, 1'b0);
    tick();
    drive(enc_r(5'd31, 5'd0, 5'd0, 6'h08), 5'd0);
    check("ex_precedence_no_stall", Stall, 1'b0);
    tick();

    // Mult occupancy: mflo stalls MDStart cycle + 5 busy cycles.
    drive(enc_r(5'd1, 5'd2, 5'd0, 6'h18), 5'd0);
    check("mult_issue_stall", Stall,   1'b0);
    check("mult_pre_start",   MDStart, 1'b0);
    tick();
    drive(enc_r(5'd0, 5'd0, 5'd3, 6'h12), 5'd3);
    check("mult_start_pulse", MDStart, 1'b1);
    check("mult_start_busy",  MDBusy,  1'b0);
    check("mflo_stall_start", Stall,   1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("mult_busy_%0d", i),  MDBusy,  1'b1);
      check($sformatf("mult_nostart_%0d", i), MDStart, 1'b0);
      check($sformatf("mflo_stall_%0d", i), Stall,   1'b1);
    end
    tick();
    check("mult_busy_fall", MDBusy, 1'b0);
    check("mflo_issue",     Stall,  1'b0);
    tick();

    // Div, then asynchronous reset at busy count 4.
    drive(enc_r(5'd1, 5'd2, 5'd0, 6'h1a), 5'd0);
    check("div_issue", Stall, 1'b0);
    tick();
    drive(32'h0, 5'd0);
    check("div_start_pulse", MDStart, 1'b1);
    tick();
    check("div_busy_first", MDBusy,  1'b1);
    check("div_start_end",  MDStart, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    drive(enc_i(6'h23, 5'd0, 5'd9, 16'h0), 5'd9);
    check("div_busy_count5", MDBusy, 1'b1);
    check("lw9_issue",       Stall,  1'b0);
    tick();
    drive(enc_r(5'd0, 5'd0, 5'd11, 6'h10), 5'd11);
    check("div_busy_count4", MDBusy, 1'b1);
    check("mfhi_md_stall",   Stall,  1'b1);
    #1;
    rst = 1'b1;
    drive(enc_r(5'd9, 5'd9, 5'd10, 6'h21), 5'd10);
    check("async_rst_mdbusy",  MDBusy,  1'b0);
    check("async_rst_mdstart", MDStart, 1'b0);
    check("async_rst_stall",   Stall,   1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_mdbusy", MDBusy, 1'b0);
    check("post_rst_stall",  Stall,  1'b0);
    drive(32'h0, 5'd0);
    tick();
    check("post_rst_idle_busy",  MDBusy,  1'b0);
    check("post_rst_idle_start", MDStart, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
